// File: rtl/id_ex_stage.sv
// ID/EX pipeline register built as a 2-entry in-order skid buffer.
// Write-back results are forwarded into entries at capture time and while they are held.
module id_ex_stage #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] rs_a,
   input  logic [ADDR_W-1:0] rt_a,
   input  logic [ADDR_W-1:0] rd_a,
   input  logic [DATA_W-1:0] rs,
   input  logic [DATA_W-1:0] rt,
   input  logic [DATA_W-1:0] imm,
   input  logic [3:0]        opcode,
   input  logic              reg_write,
   input  logic              wb_write,
   input  logic [ADDR_W-1:0] wb_rd_a,
   input  logic [DATA_W-1:0] wb_rd,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] ex_rs,
   output logic [DATA_W-1:0] ex_rt,
   output logic [DATA_W-1:0] ex_imm,
   output logic [ADDR_W-1:0] ex_rd_a,
   output logic [3:0]        ex_opcode,
   output logic              ex_reg_write
);

   typedef struct packed {
      logic [ADDR_W-1:0] rs_a;
      logic [ADDR_W-1:0] rt_a;
      logic [ADDR_W-1:0] rd_a;
      logic [DATA_W-1:0] rs;
      logic [DATA_W-1:0] rt;
      logic [DATA_W-1:0] imm;
      logic [3:0]        opcode;
      logic              reg_write;
   } entry_t;

   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

   state_t state_q, state_d;
   entry_t head_q, head_d, skid_q, skid_d, in_e;
   logic   push, pop;

   // Replace source operands whose address matches an active write-back.
   function automatic entry_t fwd(input entry_t e, input logic we,
                                  input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      entry_t r;
      r = e;
      if (we && (e.rs_a == a)) r.rs = d;
      if (we && (e.rt_a == a)) r.rt = d;
      return r;
   endfunction

   always_comb begin
      in_e.rs_a      = rs_a;
      in_e.rt_a      = rt_a;
      in_e.rd_a      = rd_a;
      in_e.rs        = rs;
      in_e.rt        = rt;
      in_e.imm       = imm;
      in_e.opcode    = opcode;
      in_e.reg_write = reg_write;
      in_e           = fwd(in_e, wb_write, wb_rd_a, wb_rd);
   end

   assign push = in_valid & in_ready;
   assign pop  = out_valid & out_ready;

   // Next state and next contents of both slots; held entries track write-back.
   always_comb begin
      state_d = state_q;
      head_d  = (state_q != EMPTY) ? fwd(head_q, wb_write, wb_rd_a, wb_rd) : head_q;
      skid_d  = (state_q == FULL) ? fwd(skid_q, wb_write, wb_rd_a, wb_rd) : skid_q;
      if (flush) begin
         state_d = EMPTY;
         head_d  = head_q;
         skid_d  = skid_q;
      end else begin
         case (state_q)
            EMPTY: begin
               if (push) begin
                  state_d = ONE;
                  head_d  = in_e;
               end
            end
            ONE: begin
               if (push && pop) begin
                  head_d = in_e;
               end else if (push) begin
                  state_d = FULL;
                  skid_d  = in_e;
               end else if (pop) begin
                  state_d = EMPTY;
                  head_d  = head_q;
               end
            end
            FULL: begin
               if (pop) begin
                  state_d = ONE;
                  head_d  = fwd(skid_q, wb_write, wb_rd_a, wb_rd);
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= EMPTY;
         head_q       <= '0;
         skid_q       <= '0;
         out_valid    <= 1'b0;
         in_ready     <= 1'b1;
         ex_reg_write <= 1'b0;
      end else begin
         state_q      <= state_d;
         head_q       <= head_d;
         skid_q       <= skid_d;
         out_valid    <= (state_d != EMPTY);
         in_ready     <= (state_d != FULL);
         ex_reg_write <= head_d.reg_write & (state_d != EMPTY);
      end
   end

   assign ex_rs     = head_q.rs;
   assign ex_rt     = head_q.rt;
   assign ex_imm    = head_q.imm;
   assign ex_rd_a   = head_q.rd_a;
   assign ex_opcode = head_q.opcode;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, operand/immediate width.
REQ-002 The block SHALL have parameter ADDR_W, default 6, register-address width (64 registers).
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 The block SHALL have port flush  input  1  synchronous discard of all held entries.
REQ-006 The block SHALL have port in_valid  input  1  decode stage offers an entry.
REQ-007 The block SHALL have port in_ready  output  1  entry can be accepted this cycle.
REQ-008 The block SHALL have ports rs_a, rt_a, rd_a  input  ADDR_W each  source/destination register addresses.
REQ-009 The block SHALL have ports rs, rt  input  DATA_W each  operands read from register file.
REQ-010 The block SHALL have ports imm  input  DATA_W, opcode  input  4, reg_write  input  1  decoded fields.
REQ-011 The block SHALL have ports wb_write  input  1, wb_rd_a  input  ADDR_W, wb_rd  input  DATA_W  write-back bus (same values driven to register file write, rd_a, rd).
REQ-012 The block SHALL have port out_valid  output  1  execute-side entry present.
REQ-013 The block SHALL have port out_ready  input  1  execute stage consumes entry.
REQ-014 The block SHALL have ports ex_rs, ex_rt, ex_imm  output  DATA_W; ex_rd_a  output  ADDR_W; ex_opcode  output  4; ex_reg_write  output  1  head entry fields.

Function
REQ-015 Input transfer SHALL occur on a rising edge with in_valid && in_ready; output transfer on rising edge with out_valid && out_ready.
REQ-016 Storage SHALL be a 2-entry in-order skid buffer (head register driving ex_* outputs, skid register behind it) with state EMPTY, ONE, FULL.
REQ-017 in_ready SHALL be 1 in EMPTY and ONE, 0 in FULL, derived from registered state only (no combinational path from out_ready).
REQ-018 out_valid SHALL be 1 in ONE and FULL, 0 in EMPTY.
REQ-019 Transitions: EMPTY+in→ONE; ONE+in only→FULL; ONE+out only→EMPTY; ONE+in+out→ONE (new entry becomes head); FULL+out→ONE (skid moves to head); otherwise hold.
REQ-020 Latency SHALL be one cycle: an entry accepted at edge N is visible on ex_* with out_valid=1 after edge N when the buffer was EMPTY.
REQ-021 Capture forwarding: when wb_write=1 and wb_rd_a==rs_a at the accepting edge, the stored rs SHALL be wb_rd instead of rs; same rule independently for rt/rt_a.
REQ-022 Hold forwarding: on every edge, each held entry whose stored rs_a (or rt_a) equals wb_rd_a with wb_write=1 SHALL replace its stored rs (or rt) with wb_rd, including the entry leaving on that edge's replacement path.
REQ-023 Register address 0 SHALL receive no special treatment; forwarding applies to it.
REQ-024 Stored fields SHALL be bit-exact copies; no arithmetic or width change is performed.
REQ-025 flush=1 SHALL move state to EMPTY on that edge, discard any simultaneous input transfer, and take priority over all transitions.
REQ-026 ex_* outputs SHALL hold last value when out_valid=0; ex_reg_write SHALL be forced 0 when out_valid=0.

Reset
REQ-027 rst=1 SHALL immediately (without clock) set state EMPTY, out_valid=0, in_ready=1, all ex_* outputs and stored fields to 0.
REQ-028 rst asserted mid-operation SHALL discard all held entries; first post-reset acceptance behaves as from EMPTY.
REQ-029 Release of rst SHALL not by itself produce any transfer.

Verification
REQ-030 Reset then rs_a=3, rs=0x11, in_valid=1 one cycle, out_ready=1 -> next cycle out_valid=1, ex_rs=0x11; following cycle out_valid=0.
REQ-031 out_ready=0, push entries A(imm=0xA) and B(imm=0xB) -> in_ready=0 after second edge; raise out_ready -> ex_imm=0xA then 0xB, in_ready returns 1 after first drain.
REQ-032 Accept rs_a=5, rs=0x1 while wb_write=1, wb_rd_a=5, wb_rd=0x99 -> ex_rs=0x99; with wb_rd_a=6 -> ex_rs=0x1.
REQ-033 Hold entry with rt_a=7 under out_ready=0, then one-cycle wb_write=1, wb_rd_a=7, wb_rd=0x55 -> ex_rt=0x55 from next cycle onward.
REQ-034 FULL state, flush=1 with in_valid=1 same edge -> state EMPTY, out_valid=0, in_ready=1, pushed entry lost.
REQ-035 Assert rst asynchronously between edges while FULL -> out_valid=0 and ex_rs=0 before next rising edge.
